// File: rtl/mult_div_if.sv
// EX-stage <-> multiply/divide unit handshake bundle.
interface mult_div_if #(parameter int DATA_WIDTH = 32);
  logic                    start;
  logic                    ack;
  logic                    flush;
  logic [2:0]              op;
  logic [DATA_WIDTH-1:0]   operand_1;
  logic [DATA_WIDTH-1:0]   operand_2;
  logic [DATA_WIDTH-1:0]   hi_i;
  logic [DATA_WIDTH-1:0]   lo_i;
  logic                    busy;
  logic                    done;
  logic                    div_by_zero;
  logic [2*DATA_WIDTH-1:0] result;

  modport master (output start, ack, flush, op, operand_1, operand_2, hi_i, lo_i,
                  input  busy, done, div_by_zero, result);
  modport slave  (input  start, ack, flush, op, operand_1, operand_2, hi_i, lo_i,
                  output busy, done, div_by_zero, result);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MUL_STEP-bit multiplier / radix-2 restoring divider with HI/LO accumulate.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STEP   = 1
) (
  input logic       clk,
  input logic       rst_n,
  mult_div_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CW    = $clog2(W) + 1;
  localparam int K_MUL = W / MUL_STEP;

  generate
    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8) ||
        (DATA_WIDTH % MUL_STEP) != 0) begin : g_bad_step
      $error("mult_div_unit: illegal MUL_STEP");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]    op_q;
  logic          s1, s2, dbz_q;
  logic [2*W-1:0] acc_q, mcand, prod, result_q;
  logic [W-1:0]  mplier, quo_q, rem_q;
  logic [CW-1:0] cnt;

  // operand capture
  logic         signed_in, is_div_in, neg1, neg2;
  logic [W-1:0] mag1_in, mag2_in;
  assign signed_in = ~bus.op[0];
  assign is_div_in = (bus.op == 3'd2) || (bus.op == 3'd3);
  assign neg1      = signed_in & bus.operand_1[W-1];
  assign neg2      = signed_in & bus.operand_2[W-1];
  assign mag1_in   = neg1 ? -bus.operand_1 : bus.operand_1;
  assign mag2_in   = neg2 ? -bus.operand_2 : bus.operand_2;

  // MUL_STEP partial products per cycle
  logic [2*W-1:0] pp;
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_STEP; j++)
      if (mplier[j]) pp = pp + (mcand << j);
  end

  // restoring step: mplier holds the divisor magnitude during DIV
  logic [W:0]   rem_sh, diff;
  logic         q_bit;
  logic [W-1:0] rem_nxt;
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign diff    = rem_sh - {1'b0, mplier};
  assign q_bit   = ~diff[W];
  assign rem_nxt = q_bit ? diff[W-1:0] : rem_sh[W-1:0];

  logic           sgn, neg_res;
  logic [2*W-1:0] prod_s, fix_res;
  logic [W-1:0]   quo_s, rem_s, op1_raw;
  always_comb begin
    sgn     = ~op_q[0];
    neg_res = sgn & (s1 ^ s2);
    prod_s  = neg_res ? -prod : prod;
    quo_s   = neg_res ? -quo_q : quo_q;
    rem_s   = (sgn & s1) ? -rem_q : rem_q;
    op1_raw = s1 ? -mcand[W-1:0] : mcand[W-1:0];
    unique case (op_q)
      3'd2, 3'd3: fix_res = dbz_q ? {op1_raw, {W{1'b1}}} : {rem_s, quo_s};
      3'd4, 3'd5: fix_res = acc_q + prod_s;
      3'd6, 3'd7: fix_res = acc_q - prod_s;
      default:    fix_res = prod_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start)
              state_nxt = !is_div_in ? MUL : (bus.operand_2 == '0) ? FIX : DIV;
      MUL:  if (cnt == CW'(K_MUL - 1)) state_nxt = FIX;
      DIV:  if (cnt == CW'(W - 1))     state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0; s1 <= 1'b0; s2 <= 1'b0; dbz_q <= 1'b0;
      acc_q <= '0; mcand <= '0; prod <= '0; result_q <= '0;
      mplier <= '0; quo_q <= '0; rem_q <= '0; cnt <= '0;
    end else if (!bus.flush) begin
      unique case (state)
        IDLE: if (bus.start) begin
          op_q   <= bus.op;
          s1     <= neg1;
          s2     <= neg2;
          mcand  <= {{W{1'b0}}, mag1_in};
          mplier <= mag2_in;
          quo_q  <= mag1_in;
          rem_q  <= '0;
          prod   <= '0;
          acc_q  <= {bus.hi_i, bus.lo_i};
          cnt    <= '0;
          dbz_q  <= is_div_in && (bus.operand_2 == '0);
        end
        MUL: begin
          prod   <= prod + pp;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + CW'(1);
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[W-2:0], q_bit};
          cnt   <= cnt + CW'(1);
        end
        FIX: result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == MUL) || (state == DIV) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.result      = result_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide/accumulate engine for the EX stage.
- Replaces the single-shot product path and drives EX's `mult_div_done` / `mult_div_result` for MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU.
- Multiplier retires MUL_STEP bits per cycle; divider is radix-2 restoring.
- Adds HI/LO accumulate, defined divide-by-zero behaviour, pipeline flush and a done/ack handshake.

Parameters:
- DATA_WIDTH, 32, operand width; HI and LO are each DATA_WIDTH bits.
- MUL_STEP, 1, multiplier bits retired per cycle. Legal values are 1, 2, 4, 8, and DATA_WIDTH % MUL_STEP must be 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- ack  in  1  EX stage advancing; releases DONE.
- flush  in  1  pipeline flush (exception/eret); aborts the current operation.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- operand_1  in  DATA_WIDTH  multiplicand / dividend.
- operand_2  in  DATA_WIDTH  multiplier / divisor.
- hi_i  in  DATA_WIDTH  accumulator high half, sampled with start.
- lo_i  in  DATA_WIDTH  accumulator low half, sampled with start.
- busy  out  1  high in states MUL, DIV, FIX.
- done  out  1  high in state DONE.
- div_by_zero  out  1  sticky for the current result; cleared on the next accepted start.
- result  out  2*DATA_WIDTH  {HI, LO}; held stable outside FIX.

Behaviour:
- Reset (rst_n low, async): state IDLE, busy 0, done 0, div_by_zero 0, result 0, iteration counter 0.
- Reset mid-operation discards all work.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, flush=0 at edge E0:
  - latch op, |operands| (magnitude; sign taken only for signed ops), the sign bits, and {hi_i, lo_i}.
  - clear the counter.
  - go to MUL (op 0, 1, 4–7) or DIV (op 2, 3).
  - DIV/DIVU with operand_2 == 0: go to FIX instead and set div_by_zero.
- MUL: each edge adds MUL_STEP partial products into a 2W accumulator; advance counter.
  - After K = DATA_WIDTH/MUL_STEP edges, go to FIX.
- DIV: one restoring shift-subtract per edge; after K = DATA_WIDTH edges, go to FIX.
- FIX (one edge): sign correction, then write result and go to DONE.
  - Product: negate if s1^s2 (signed ops).
  - Quotient: negate if s1^s2. Remainder: takes the sign of the dividend.
  - MADD/MADDU: result = {hi,lo} + product. MSUB/MSUBU: result = {hi,lo} − product. Both modulo 2^(2W), no flag.
  - DIV/DIVU: result = {remainder, quotient}.
  - Divide by zero: result = {operand_1, all-ones}.
  - Signed overflow: MIN / −1 gives quotient MIN, remainder 0 (natural wrap).
- Latency: done is high after edge E0+K+1. Divide by zero: done after E0+1.
- DONE: done=1, result held. On ack=1, go to IDLE at that edge.
  - A new start is not accepted on the same edge as ack; the earliest acceptance is the next edge, so a held start behind a stalled EX never restarts the op.
- start in MUL/DIV/FIX/DONE is ignored.
- flush=1 in any state: go to IDLE on the next edge. done/busy drop; result is not updated. flush beats start and ack on the same edge.
- Counter width is $clog2(DATA_WIDTH)+1. Elaboration fails if the MUL_STEP rules are violated.

Test Plan:
1. Signed multiply, W=32, S=1: MULT 0xFFFFFFFE × 3 → result 0xFFFFFFFF_FFFFFFFA, done first high after edge E0+33, busy high edges E0..E0+32.
2. DIVU 100/7 → HI 2, LO 14. DIV −7/2 → HI 0xFFFFFFFF, LO 0xFFFFFFFD. DIV 0x80000000 / 0xFFFFFFFF → HI 0, LO 0x80000000.
3. Accumulate: MADDU with hi_i=0, lo_i=0xFFFFFFFF, 1×1 → 0x00000001_00000000. MSUBU with hi_i=lo_i=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
4. Divide by zero: DIV 5/0 → div_by_zero=1, result 0x00000005_FFFFFFFF, done after E0+1. The next accepted start clears the flag.
5. Handshake: hold ack low for 5 cycles with start held high → done stays 1, result stable, no restart. Pulse ack → IDLE, and the following start is accepted one edge later.
6. Abort and scaling:
   - flush at DIV iteration 10 → IDLE next edge, done never rises, result unchanged.
   - rst_n low mid-MUL → all outputs 0 immediately.
   - MUL_STEP=4 MULT 7×9 → 63 with done after E0+9.
